// File: rtl/imm_pkg.sv
// Shared types and constants for the writable immediate table.
// The default immediate set is reloaded at boot and on restore.
package imm_pkg;

  localparam int unsigned IMM_ENTRIES = 8;
  localparam int unsigned IMM_W       = 8;
  localparam int unsigned IMM_IDX_W   = 3;

  typedef enum logic [1:0] {
    INIT   = 2'd0,
    RUN    = 2'd1,
    LOCKED = 2'd2
  } imm_state_t;

  localparam logic [IMM_W-1:0] IMM_DEFAULT [IMM_ENTRIES] = '{
    8'h00, 8'h01, 8'h1E, 8'h05, 8'hF8, 8'h54, 8'hE2, 8'hFF
  };

  function automatic logic [IMM_W-1:0] imm_default(input logic [IMM_IDX_W-1:0] idx);
    return IMM_DEFAULT[idx];
  endfunction

endpackage

// File: rtl/imm_regfile.sv
// 8x8 immediate storage: one write port, one registered write-first read port.
module imm_regfile
  import imm_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 we,
  input  logic [IMM_IDX_W-1:0] waddr,
  input  logic [IMM_W-1:0]     wdata,
  input  logic                 re,
  input  logic [IMM_IDX_W-1:0] raddr,
  output logic [IMM_W-1:0]     rdata
);

  logic [IMM_W-1:0] mem [IMM_ENTRIES];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // A same-cycle write to the read index bypasses storage.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= (we && (waddr == raddr)) ? wdata : mem[raddr];
    end
  end

endmodule

// File: rtl/imm_table_ctrl.sv
// Immediate table controller: boot/restore loader, decode lookups, config writes.
// Optional write lock is enabled by defining IMM_WR_LOCK_EN.
module imm_table_ctrl
  import imm_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       rd_en,
  input  logic [2:0] rd_idx,
  output logic [7:0] immed,
  output logic       imm_valid,
  input  logic       wr_valid,
  input  logic [2:0] wr_idx,
  input  logic [7:0] wr_data,
  output logic       wr_ready,
  input  logic       restore,
  input  logic       lock,
  output logic       init_done
);

  imm_state_t           state;
  logic [IMM_IDX_W-1:0] cnt;
  logic                 load_we;
  logic                 cfg_we;
  logic                 rf_we;
  logic [IMM_IDX_W-1:0] rf_waddr;
  logic [IMM_W-1:0]     rf_wdata;
  logic                 rf_re;

`ifdef IMM_WR_LOCK_EN
  logic ret_locked;
`else
  logic unused_lock;
  assign unused_lock = lock;
`endif

  assign init_done = (state != INIT);
  assign wr_ready  = (state == RUN);

  assign load_we = (state == INIT);
  assign cfg_we  = wr_valid && wr_ready;

  // Reset suppresses any write in its cycle, including the loader's.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = wr_idx;
    rf_wdata = wr_data;
    if (!reset) begin
      if (load_we) begin
        rf_we    = 1'b1;
        rf_waddr = cnt;
        rf_wdata = imm_default(cnt);
      end else if (cfg_we) begin
        rf_we = 1'b1;
      end
    end
  end

  assign rf_re = rd_en && (state != INIT);

  imm_regfile u_regfile (
    .clk   (clk),
    .reset (reset),
    .we    (rf_we),
    .waddr (rf_waddr),
    .wdata (rf_wdata),
    .re    (rf_re),
    .raddr (rd_idx),
    .rdata (immed)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= INIT;
      cnt       <= '0;
      imm_valid <= 1'b0;
`ifdef IMM_WR_LOCK_EN
      ret_locked <= 1'b0;
`endif
    end else begin
      imm_valid <= rf_re;
      case (state)
        INIT: begin
          if (restore) begin
            cnt <= '0;
          end else begin
            cnt <= cnt + 3'd1;
            if (cnt == 3'(IMM_ENTRIES - 1)) begin
`ifdef IMM_WR_LOCK_EN
              state <= ret_locked ? LOCKED : RUN;
`else
              state <= RUN;
`endif
            end
          end
        end
        RUN: begin
          if (restore) begin
            state <= INIT;
            cnt   <= '0;
`ifdef IMM_WR_LOCK_EN
          end else if (lock) begin
            state      <= LOCKED;
            ret_locked <= 1'b1;
`endif
          end
        end
`ifdef IMM_WR_LOCK_EN
        LOCKED: begin
          if (restore) begin
            state <= INIT;
            cnt   <= '0;
          end
        end
`endif
        default: begin
          state <= INIT;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
